// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the CPU
// and a debug/DMA requester; read data returns with a valid strobe one cycle later.
module mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CPU = 2'd1,
        RD_DBG = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_win_q, last_win_d;   // 0 = CPU won last, 1 = DBG won last
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              cpu_win, dbg_win;

    // Winner selection; grants are held low while reset is asserted.
    always_comb begin
        cpu_win = 1'b0;
        dbg_win = 1'b0;
        if (rst_n) begin
            if (cpu_req && dbg_req) begin
                cpu_win = last_win_q;
                dbg_win = ~last_win_q;
            end else begin
                cpu_win = cpu_req;
                dbg_win = dbg_req;
            end
        end
    end

    assign cpu_gnt   = cpu_win;
    assign dbg_gnt   = dbg_win;
    assign ram_addr  = dbg_win ? dbg_addr  : cpu_addr;
    assign ram_din   = dbg_win ? dbg_wdata : cpu_wdata;
    assign ram_write = (cpu_win & cpu_we) | (dbg_win & dbg_we);

    always_comb begin
        last_win_d  = last_win_q;
        state_d     = IDLE;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;

        if (cpu_win) begin
            last_win_d = 1'b0;
        end else if (dbg_win) begin
            last_win_d = 1'b1;
        end

        if (cpu_win && !cpu_we) begin
            state_d = RD_CPU;
        end else if (dbg_win && !dbg_we) begin
            state_d = RD_DBG;
        end

        if (state_q == RD_CPU) begin
            cpu_rdata_d = ram_dout;
        end
        if (state_q == RD_DBG) begin
            dbg_rdata_d = ram_dout;
        end
    end

    // The RAM output is only valid during the return cycle, so it is forwarded
    // directly then and captured for the hold period afterwards.
    assign cpu_rvalid = (state_q == RD_CPU);
    assign dbg_rvalid = (state_q == RD_DBG);
    assign cpu_rdata  = cpu_rvalid ? ram_dout : cpu_rdata_q;
    assign dbg_rdata  = dbg_rvalid ? ram_dout : dbg_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_win_q  <= 1'b1;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_win_q  <= last_win_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed test-plan scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural arbitration/RAM model.
module tb_mem_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              cpu_req, cpu_we, dbg_req, dbg_we;
    logic [ADDR_W-1:0] cpu_addr, dbg_addr;
    logic [DATA_W-1:0] cpu_wdata, dbg_wdata;
    logic              cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [DATA_W-1:0] cpu_rdata, dbg_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_write;
    logic [DATA_W-1:0] ram_dout;

    int vectors;
    int miscompares;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_write(ram_write), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pat(int a);
        return 16'(((a * 257) ^ 16'h5A5A) & 16'hFFFF);
    endfunction

    // RAM macro the arbiter drives: synchronous read, write on the clock edge.
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // Reference model state: expected memory contents, round-robin pointer,
    // pending read return and the last data each port received.
    logic [DATA_W-1:0] shadow [0:DEPTH-1];
    bit                m_last;          // 1: DBG won last time
    int                m_pend;          // 0 none, 1 CPU, 2 DBG
    logic [DATA_W-1:0] m_pdata, m_crd, m_drd;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = pat(i);
            shadow[i] = pat(i);
        end
        mem[5]    = 16'hBEEF;
        shadow[5] = 16'hBEEF;
        ram_dout  = '0;
        m_last = 1'b1; m_pend = 0; m_pdata = '0; m_crd = '0; m_drd = '0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle model compare, sampled mid-cycle after inputs have settled.
    always @(negedge clk) begin
        int win;   // 0 none, 1 CPU, 2 DBG
        if (!rst_n) begin
            m_last = 1'b1; m_pend = 0; m_crd = '0; m_drd = '0;
            chk("m_rst_cpu_gnt", cpu_gnt, 0);
            chk("m_rst_dbg_gnt", dbg_gnt, 0);
            chk("m_rst_ram_write", ram_write, 0);
            chk("m_rst_cpu_rvalid", cpu_rvalid, 0);
            chk("m_rst_dbg_rvalid", dbg_rvalid, 0);
            chk("m_rst_cpu_rdata", cpu_rdata, 0);
            chk("m_rst_dbg_rdata", dbg_rdata, 0);
        end else begin
            if (m_pend == 1) m_crd = m_pdata;
            if (m_pend == 2) m_drd = m_pdata;
            chk("m_cpu_rvalid", cpu_rvalid, (m_pend == 1) ? 1 : 0);
            chk("m_dbg_rvalid", dbg_rvalid, (m_pend == 2) ? 1 : 0);
            chk("m_cpu_rdata", cpu_rdata, m_crd);
            chk("m_dbg_rdata", dbg_rdata, m_drd);

            if (cpu_req && dbg_req) win = m_last ? 1 : 2;
            else if (cpu_req)       win = 1;
            else if (dbg_req)       win = 2;
            else                    win = 0;

            chk("m_cpu_gnt", cpu_gnt, (win == 1) ? 1 : 0);
            chk("m_dbg_gnt", dbg_gnt, (win == 2) ? 1 : 0);
            chk("m_ram_addr", ram_addr, (win == 2) ? dbg_addr : cpu_addr);
            chk("m_ram_write", ram_write, (win == 1) ? cpu_we : (win == 2) ? dbg_we : 1'b0);

            m_pend = 0;
            if (win == 1) begin
                m_last = 1'b0;
                if (cpu_we) begin
                    chk("m_ram_din", ram_din, cpu_wdata);
                    shadow[cpu_addr] = cpu_wdata;
                end else begin
                    m_pend = 1; m_pdata = shadow[cpu_addr];
                end
            end else if (win == 2) begin
                m_last = 1'b1;
                if (dbg_we) begin
                    chk("m_ram_din", ram_din, dbg_wdata);
                    shadow[dbg_addr] = dbg_wdata;
                end else begin
                    m_pend = 2; m_pdata = shadow[dbg_addr];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic reset_pulse();
        step();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    initial begin
        int ncpu, ndbg;
        bit cg, dg;
        vectors = 0;
        miscompares = 0;
        rst_n = 0;
        idle_inputs();
        step();
        @(negedge clk);
        chk("reset_cpu_gnt", cpu_gnt, 0);
        chk("reset_cpu_rdata", cpu_rdata, 0);
        rst_n = 1;

        // Single CPU read of 0x005
        cpu_req = 1; cpu_addr = 10'h005;
        @(negedge clk);
        chk("t1_cpu_gnt", cpu_gnt, 1);
        chk("t1_dbg_gnt", dbg_gnt, 0);
        step();
        idle_inputs();
        @(negedge clk);
        chk("t1_cpu_rvalid", cpu_rvalid, 1);
        chk("t1_cpu_rdata", cpu_rdata, 16'hBEEF);
        chk("t1_dbg_rvalid", dbg_rvalid, 0);
        chk("t1_dbg_rdata", dbg_rdata, 0);

        // First tie after reset, then strict alternation
        reset_pulse();
        cpu_req = 1; dbg_req = 1; cpu_addr = 10'h020; dbg_addr = 10'h021;
        ncpu = 0; ndbg = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) chk("t2_first_cpu", {30'd0, cpu_gnt, dbg_gnt}, 2'b10);
            if (i == 1) chk("t2_second_dbg", {30'd0, cpu_gnt, dbg_gnt}, 2'b01);
            ncpu += int'(cpu_gnt);
            ndbg += int'(dbg_gnt);
            step();
        end
        idle_inputs();
        chk("t2_cpu_grants", ncpu, 4);
        chk("t2_dbg_grants", ndbg, 4);

        // DBG writes 0x1234 to 0x3FF, CPU reads it back the next cycle
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'h3FF; dbg_wdata = 16'h1234;
        @(negedge clk);
        chk("t3_dbg_wr_gnt", dbg_gnt, 1);
        step();
        idle_inputs();
        cpu_req = 1; cpu_addr = 10'h3FF;
        @(negedge clk);
        chk("t3_no_wr_rvalid", dbg_rvalid, 0);
        chk("t3_cpu_gnt", cpu_gnt, 1);
        step();
        idle_inputs();
        @(negedge clk);
        chk("t3_cpu_rvalid", cpu_rvalid, 1);
        chk("t3_cpu_rdata", cpu_rdata, 16'h1234);

        // DBG streams reads of 0x010..0x013
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                dbg_req = 1; dbg_addr = ADDR_W'(16 + i);
            end else begin
                idle_inputs();
            end
            @(negedge clk);
            if (i < 4) chk("t4_dbg_gnt", dbg_gnt, 1);
            if (i > 0) begin
                chk("t4_dbg_rvalid", dbg_rvalid, 1);
                chk("t4_dbg_rdata", dbg_rdata, pat(16 + i - 1));
            end
            step();
        end

        // Reset in the cycle after a CPU read grant
        cpu_req = 1; cpu_addr = 10'h005;
        @(negedge clk);
        chk("t5_cpu_gnt", cpu_gnt, 1);
        step();
        rst_n = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h040; cpu_wdata = 16'hC0DE;
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'h041; dbg_wdata = 16'hD00D;
        @(negedge clk);
        chk("t5_rst_rvalid", cpu_rvalid, 0);
        chk("t5_rst_rdata", cpu_rdata, 0);
        chk("t5_rst_gnt", {30'd0, cpu_gnt, dbg_gnt}, 0);
        step();
        rst_n = 1;
        @(negedge clk);
        chk("t5_tie_cpu", {30'd0, cpu_gnt, dbg_gnt}, 2'b10);
        step();
        idle_inputs();

        // Idle for five cycles; the next tie must go to DBG
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_idle", {28'd0, ram_write, cpu_gnt, dbg_gnt, cpu_rvalid | dbg_rvalid}, 0);
            step();
        end
        cpu_req = 1; dbg_req = 1; cpu_addr = 10'h050; dbg_addr = 10'h051;
        @(negedge clk);
        chk("t6_tie_dbg", {30'd0, cpu_gnt, dbg_gnt}, 2'b01);
        step();
        idle_inputs();

        // Random traffic; requesters hold their request until granted or dropped.
        cg = 0; dg = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            cg = cpu_gnt;
            dg = dbg_gnt;
            step();
            rst_n = ($urandom_range(0, 299) != 0);
            if (!(cpu_req && !cg && $urandom_range(0, 7) != 0)) begin
                cpu_req   = ($urandom_range(0, 9) < 6);
                cpu_we    = ($urandom_range(0, 9) < 3);
                cpu_addr  = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 15))
                                                         : ADDR_W'($urandom_range(1008, 1023));
                cpu_wdata = DATA_W'($urandom);
            end
            if (!(dbg_req && !dg && $urandom_range(0, 7) != 0)) begin
                dbg_req   = ($urandom_range(0, 9) < 6);
                dbg_we    = ($urandom_range(0, 9) < 3);
                dbg_addr  = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 15))
                                                         : ADDR_W'($urandom_range(1008, 1023));
                dbg_wdata = DATA_W'($urandom);
            end
        end
        rst_n = 1;
        idle_inputs();
        step();
        @(negedge clk);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
